dcr_fetch_if: RTL and testbench

Instruction-fetch stage of the single-core DCR pipeline, directly upstream of the decode/write-back stage. Holds the 8-bit PC and drives a request/ready instruction-memory port. Selects the next PC from sequential, branch, jump or register targets returned by decode. Registers the fetched instruction and PC+1 into the IF/ID pipeline register, inserting NOP bubbles on memory wait, redirect or flush.

---
 rtl/dcr_pkg.sv | 22 ++
 rtl/dcr_pc_sel.sv | 31 +++
 rtl/dcr_fetch_if.sv | 155 +++++++++++++++
 tb/tb_dcr_fetch_if.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dcr_pkg.sv
// Shared types and constants for the DCR fetch stage.
package dcr_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;
    localparam logic [1:0] PCSRC_REG = 2'b11;

    localparam logic [31:0] DCR_NOP = 32'd0;

    function automatic logic [7:0] pc_inc(input logic [7:0] pc);
        return pc + 8'd1;
    endfunction

endpackage

// File: rtl/dcr_pc_sel.sv
// Next-PC mux and 8-bit incrementer (modulo 256).
// Latency: combinational.
// Backpressure: none; the caller decides when next_pc is taken.
module dcr_pc_sel
    import dcr_pkg::*;
(
    input  logic [7:0] pc,
    input  logic [1:0] pcsrc,
    input  logic [7:0] branch_target,
    input  logic [7:0] jump_target,
    input  logic [7:0] reg_target,
    output logic [7:0] pc_plus_one,
    output logic [7:0] next_pc,
    output logic       redirect
);

    assign pc_plus_one = pc_inc(pc);
    assign redirect    = (pcsrc != PCSRC_SEQ);

    always_comb begin
        next_pc = pc_plus_one;
        case (pcsrc)
            PCSRC_SEQ: next_pc = pc_plus_one;
            PCSRC_BR:  next_pc = branch_target;
            PCSRC_JMP: next_pc = jump_target;
            PCSRC_REG: next_pc = reg_target;
            default:   next_pc = pc_plus_one;
        endcase
    end

endmodule

// File: rtl/dcr_fetch_if.sv
// Instruction fetch: PC, imem request/ready port, IF/ID register (optional perf counters: DCR_FETCH_PERF_EN).
// Latency: 1 edge from address presented (with ready) to instruction at decode.
// Backpressure: clken=0 freezes ID/PC; a word that arrives while stalled is parked in a hold buffer.
module dcr_fetch_if
    import dcr_pkg::*;
#(
    parameter logic [7:0]  RESET_PC  = 8'd0,
    parameter logic [31:0] NOP_INSTR = DCR_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clken,
    input  logic        FlushInIF,
    input  logic [1:0]  PCSrcInIF,
    input  logic [7:0]  BranchTargetInIF,
    input  logic [7:0]  JumpTargetInIF,
    input  logic [7:0]  RegTargetInIF,
    output logic [7:0]  IMemAddrOut,
    output logic        IMemReqOut,
    input  logic        IMemReadyIn,
    input  logic [31:0] IMemDataIn,
    output logic [31:0] InstructionOutID,
    output logic [7:0]  PCPlusOneOutID,
    output logic        ValidOutID,
`ifdef DCR_FETCH_PERF_EN
    output logic [31:0] FetchCountOut,
    output logic [31:0] BubbleCountOut,
    output logic        FetchStallOut
`else
    output logic        FetchStallOut
`endif
);

    fetch_state_t state, state_n;
    logic [7:0]   pc, pc_n;
    logic [7:0]   tgt, tgt_n;
    logic [31:0]  hold_buf, hold_n;
    logic [7:0]   pc_plus_one, next_pc;
    logic         redirect;
    logic         load_valid, load_bubble;
    logic [31:0]  load_word;

    dcr_pc_sel u_pc_sel (
        .pc            (pc),
        .pcsrc         (PCSrcInIF),
        .branch_target (BranchTargetInIF),
        .jump_target   (JumpTargetInIF),
        .reg_target    (RegTargetInIF),
        .pc_plus_one   (pc_plus_one),
        .next_pc       (next_pc),
        .redirect      (redirect)
    );

    assign IMemAddrOut   = pc;
    assign IMemReqOut    = (state == S_REQ) || (state == S_DROP);
    assign FetchStallOut = (state != S_REQ) || !IMemReadyIn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        tgt_n       = tgt;
        hold_n      = hold_buf;
        load_valid  = 1'b0;
        load_bubble = 1'b0;
        load_word   = IMemDataIn;
        case (state)
            S_IDLE: begin
                state_n     = S_REQ;
                load_bubble = clken;
            end
            S_REQ: begin
                if (IMemReadyIn) begin
                    if (clken) begin
                        pc_n        = next_pc;
                        load_valid  = !redirect && !FlushInIF;
                        load_bubble = redirect || FlushInIF;
                    end else begin
                        hold_n  = IMemDataIn;
                        state_n = S_HOLD;
                    end
                end else if (clken) begin
                    load_bubble = 1'b1;
                    if (redirect) begin
                        tgt_n   = next_pc;
                        state_n = S_DROP;
                    end
                end
            end
            S_HOLD: begin
                load_word = hold_buf;
                if (clken) begin
                    pc_n        = next_pc;
                    state_n     = S_REQ;
                    load_valid  = !redirect && !FlushInIF;
                    load_bubble = redirect || FlushInIF;
                end
            end
            S_DROP: begin
                // The outstanding word belongs to the squashed path; the latest redirect wins.
                if (clken) begin
                    load_bubble = 1'b1;
                    if (redirect) tgt_n = next_pc;
                end
                if (IMemReadyIn) begin
                    pc_n    = (clken && redirect) ? next_pc : tgt;
                    state_n = S_REQ;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc               <= RESET_PC;
            tgt              <= RESET_PC;
            hold_buf         <= '0;
            InstructionOutID <= NOP_INSTR;
            PCPlusOneOutID   <= '0;
            ValidOutID       <= 1'b0;
        end else begin
            pc       <= pc_n;
            tgt      <= tgt_n;
            hold_buf <= hold_n;
            if (load_valid) begin
                InstructionOutID <= load_word;
                PCPlusOneOutID   <= pc_plus_one;
                ValidOutID       <= 1'b1;
            end else if (load_bubble) begin
                InstructionOutID <= NOP_INSTR;
                ValidOutID       <= 1'b0;
            end
        end
    end

`ifdef DCR_FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            FetchCountOut  <= '0;
            BubbleCountOut <= '0;
        end else begin
            if (load_valid && FetchCountOut != 32'hFFFF_FFFF)
                FetchCountOut <= FetchCountOut + 32'd1;
            if (load_bubble && BubbleCountOut != 32'hFFFF_FFFF)
                BubbleCountOut <= BubbleCountOut + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcr_fetch_if.sv
// Directed bench for dcr_fetch_if; memory model returns address+100.
module tb_dcr_fetch_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        clken;
    logic        FlushInIF;
    logic [1:0]  PCSrcInIF;
    logic [7:0]  BranchTargetInIF, JumpTargetInIF, RegTargetInIF;
    logic [7:0]  IMemAddrOut;
    logic        IMemReqOut;
    logic        IMemReadyIn;
    logic [31:0] IMemDataIn;
    logic [31:0] InstructionOutID;
    logic [7:0]  PCPlusOneOutID;
    logic        ValidOutID;
    logic        FetchStallOut;
`ifdef DCR_FETCH_PERF_EN
    logic [31:0] FetchCountOut, BubbleCountOut;
`endif

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    assign IMemDataIn = 32'(IMemAddrOut) + 32'd100;

    dcr_fetch_if dut (
        .clk              (clk),
        .rst              (rst),
        .clken            (clken),
        .FlushInIF        (FlushInIF),
        .PCSrcInIF        (PCSrcInIF),
        .BranchTargetInIF (BranchTargetInIF),
        .JumpTargetInIF   (JumpTargetInIF),
        .RegTargetInIF    (RegTargetInIF),
        .IMemAddrOut      (IMemAddrOut),
        .IMemReqOut       (IMemReqOut),
        .IMemReadyIn      (IMemReadyIn),
        .IMemDataIn       (IMemDataIn),
        .InstructionOutID (InstructionOutID),
        .PCPlusOneOutID   (PCPlusOneOutID),
        .ValidOutID       (ValidOutID),
`ifdef DCR_FETCH_PERF_EN
        .FetchCountOut    (FetchCountOut),
        .BubbleCountOut   (BubbleCountOut),
`endif
        .FetchStallOut    (FetchStallOut)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clken = 1'b1; FlushInIF = 1'b0; PCSrcInIF = 2'b00;
        BranchTargetInIF = 8'h00; JumpTargetInIF = 8'h00; RegTargetInIF = 8'h00;
        IMemReadyIn = 1'b1;
        #2;
        ncmp++; if (InstructionOutID !== 32'd0) begin nerr++; $display("FAIL rst_instr got %0h want 0", InstructionOutID); end
        ncmp++; if (PCPlusOneOutID !== 8'd0) begin nerr++; $display("FAIL rst_pcp1 got %0h want 0", PCPlusOneOutID); end
        ncmp++; if (ValidOutID !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b want 0", ValidOutID); end
        ncmp++; if (IMemReqOut !== 1'b0) begin nerr++; $display("FAIL rst_req got %b want 0", IMemReqOut); end
        ncmp++; if (IMemAddrOut !== 8'd0) begin nerr++; $display("FAIL rst_addr got %0h want 0", IMemAddrOut); end
        ncmp++; if (FetchStallOut !== 1'b1) begin nerr++; $display("FAIL rst_stall got %b want 1", FetchStallOut); end
        tick(); tick();
        rst = 1'b0;
        #1;
        ncmp++; if (IMemReqOut !== 1'b0) begin nerr++; $display("FAIL idle_req got %b want 0", IMemReqOut); end
        tick();
        ncmp++; if (IMemReqOut !== 1'b1) begin nerr++; $display("FAIL first_req got %b want 1", IMemReqOut); end
        ncmp++; if (ValidOutID !== 1'b0) begin nerr++; $display("FAIL first_valid got %b want 0", ValidOutID); end
        ncmp++; if (FetchStallOut !== 1'b0) begin nerr++; $display("FAIL first_stall got %b want 0", FetchStallOut); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            tick();
            ncmp++; if (InstructionOutID !== 32'(100 + i)) begin nerr++; $display("FAIL seq_instr[%0d] got %0d want %0d", i, InstructionOutID, 100 + i); end
            ncmp++; if (PCPlusOneOutID !== 8'(i + 1)) begin nerr++; $display("FAIL seq_pcp1[%0d] got %0d want %0d", i, PCPlusOneOutID, i + 1); end
            ncmp++; if (ValidOutID !== 1'b1) begin nerr++; $display("FAIL seq_valid[%0d] got %b want 1", i, ValidOutID); end
        end
    endtask

    task automatic test_wrap();
        PCSrcInIF = 2'b10; JumpTargetInIF = 8'hFF;
        tick();
        ncmp++; if (ValidOutID !== 1'b0) begin nerr++; $display("FAIL jmp_bubble got %b want 0", ValidOutID); end
        ncmp++; if (IMemAddrOut !== 8'hFF) begin nerr++; $display("FAIL jmp_addr got %0h want ff", IMemAddrOut); end
        PCSrcInIF = 2'b00;
        tick();
        ncmp++; if (InstructionOutID !== 32'd355) begin nerr++; $display("FAIL wrap_instr got %0d want 355", InstructionOutID); end
        ncmp++; if (PCPlusOneOutID !== 8'h00) begin nerr++; $display("FAIL wrap_pcp1 got %0h want 0", PCPlusOneOutID); end
        ncmp++; if (IMemAddrOut !== 8'h00) begin nerr++; $display("FAIL wrap_addr got %0h want 0", IMemAddrOut); end
    endtask

    task automatic test_wait();
        PCSrcInIF = 2'b11; RegTargetInIF = 8'h05;
        tick();
        PCSrcInIF = 2'b00; IMemReadyIn = 1'b0;
        #1;
        ncmp++; if (FetchStallOut !== 1'b1) begin nerr++; $display("FAIL wait_stall0 got %b want 1", FetchStallOut); end
        for (int i = 0; i < 3; i++) begin
            tick();
            ncmp++; if (ValidOutID !== 1'b0) begin nerr++; $display("FAIL wait_bubble[%0d] got %b want 0", i, ValidOutID); end
            ncmp++; if (IMemAddrOut !== 8'h05) begin nerr++; $display("FAIL wait_addr[%0d] got %0h want 5", i, IMemAddrOut); end
            ncmp++; if (FetchStallOut !== 1'b1) begin nerr++; $display("FAIL wait_stall[%0d] got %b want 1", i, FetchStallOut); end
        end
        IMemReadyIn = 1'b1;
        tick();
        ncmp++; if (InstructionOutID !== 32'd105) begin nerr++; $display("FAIL wait_instr got %0d want 105", InstructionOutID); end
        ncmp++; if (PCPlusOneOutID !== 8'd6) begin nerr++; $display("FAIL wait_pcp1 got %0d want 6", PCPlusOneOutID); end
    endtask

    task automatic test_hold();
        clken = 1'b0;
        tick();
        ncmp++; if (IMemReqOut !== 1'b0) begin nerr++; $display("FAIL hold_req got %b want 0", IMemReqOut); end
        ncmp++; if (FetchStallOut !== 1'b1) begin nerr++; $display("FAIL hold_stall got %b want 1", FetchStallOut); end
        ncmp++; if (InstructionOutID !== 32'd105) begin nerr++; $display("FAIL hold_frozen got %0d want 105", InstructionOutID); end
        IMemReadyIn = 1'b0;
        tick();
        ncmp++; if (IMemReqOut !== 1'b0) begin nerr++; $display("FAIL hold2_req got %b want 0", IMemReqOut); end
        clken = 1'b1;
        tick();
        ncmp++; if (InstructionOutID !== 32'd106) begin nerr++; $display("FAIL hold_deliver got %0d want 106", InstructionOutID); end
        ncmp++; if (PCPlusOneOutID !== 8'd7) begin nerr++; $display("FAIL hold_pcp1 got %0d want 7", PCPlusOneOutID); end
        ncmp++; if (IMemAddrOut !== 8'd7) begin nerr++; $display("FAIL hold_addr got %0d want 7", IMemAddrOut); end
        IMemReadyIn = 1'b1;
        tick();
        ncmp++; if (InstructionOutID !== 32'd107) begin nerr++; $display("FAIL hold_next got %0d want 107", InstructionOutID); end
    endtask

    task automatic test_drop();
        IMemReadyIn = 1'b0; PCSrcInIF = 2'b01; BranchTargetInIF = 8'h40;
        tick();
        ncmp++; if (IMemAddrOut !== 8'h08) begin nerr++; $display("FAIL drop_addr got %0h want 8", IMemAddrOut); end
        ncmp++; if (IMemReqOut !== 1'b1) begin nerr++; $display("FAIL drop_req got %b want 1", IMemReqOut); end
        ncmp++; if (ValidOutID !== 1'b0) begin nerr++; $display("FAIL drop_bubble got %b want 0", ValidOutID); end
        PCSrcInIF = 2'b10; JumpTargetInIF = 8'h80;
        tick();
        PCSrcInIF = 2'b00; IMemReadyIn = 1'b1;
        #1;
        ncmp++; if (FetchStallOut !== 1'b1) begin nerr++; $display("FAIL drop_stall got %b want 1", FetchStallOut); end
        tick();
        ncmp++; if (IMemAddrOut !== 8'h80) begin nerr++; $display("FAIL drop_target got %0h want 80", IMemAddrOut); end
        ncmp++; if (ValidOutID !== 1'b0) begin nerr++; $display("FAIL drop_discard got %b want 0", ValidOutID); end
        tick();
        ncmp++; if (InstructionOutID !== 32'd228) begin nerr++; $display("FAIL drop_instr got %0d want 228", InstructionOutID); end
        ncmp++; if (PCPlusOneOutID !== 8'h81) begin nerr++; $display("FAIL drop_pcp1 got %0h want 81", PCPlusOneOutID); end
    endtask

    task automatic test_flush();
`ifdef DCR_FETCH_PERF_EN
        logic [31:0] bub0, fet0;
        bub0 = BubbleCountOut; fet0 = FetchCountOut;
`endif
        FlushInIF = 1'b1;
        tick();
        FlushInIF = 1'b0;
        ncmp++; if (ValidOutID !== 1'b0) begin nerr++; $display("FAIL flush_valid got %b want 0", ValidOutID); end
        ncmp++; if (IMemAddrOut !== 8'h82) begin nerr++; $display("FAIL flush_addr got %0h want 82", IMemAddrOut); end
        ncmp++; if (PCPlusOneOutID !== 8'h81) begin nerr++; $display("FAIL flush_pcp1 got %0h want 81", PCPlusOneOutID); end
`ifdef DCR_FETCH_PERF_EN
        ncmp++; if (BubbleCountOut !== bub0 + 32'd1) begin nerr++; $display("FAIL flush_bubcnt got %0d want %0d", BubbleCountOut, bub0 + 32'd1); end
        ncmp++; if (FetchCountOut !== fet0) begin nerr++; $display("FAIL flush_fetcnt got %0d want %0d", FetchCountOut, fet0); end
`endif
        tick();
        ncmp++; if (InstructionOutID !== 32'd230) begin nerr++; $display("FAIL flush_next got %0d want 230", InstructionOutID); end
        ncmp++; if (PCPlusOneOutID !== 8'h83) begin nerr++; $display("FAIL flush_next_pcp1 got %0h want 83", PCPlusOneOutID); end
    endtask

    task automatic test_reset_midreq();
        IMemReadyIn = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        ncmp++; if (IMemReqOut !== 1'b0) begin nerr++; $display("FAIL mid_rst_req got %b want 0", IMemReqOut); end
        ncmp++; if (IMemAddrOut !== 8'h00) begin nerr++; $display("FAIL mid_rst_addr got %0h want 0", IMemAddrOut); end
        ncmp++; if (InstructionOutID !== 32'd0) begin nerr++; $display("FAIL mid_rst_instr got %0d want 0", InstructionOutID); end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap();
        test_wait();
        test_hold();
        test_drop();
        test_flush();
        test_reset_midreq();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
